// File: rtl/fir_axi_lite_regs.sv
// AXI4-Lite responder register bank (4 x 32-bit) for the FIR filter IP.
// Optional define FIR_AXI_REG3_STATUS_EN turns reg3 into a read-only view of status_i.
module fir_axi_lite_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      wr_pulse_o,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_i
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_GOTADDR, W_GOTDATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t        w_state_q, w_state_d;
  r_state_t        r_state_q, r_state_d;
  logic [1:0]      waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]   wstrb_q, wstrb_d;
  logic [DW-1:0]   regs_q [4];
  logic [DW-1:0]   regs_d [4];
  logic [3:0]      wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            aw_hs, w_hs, ar_hs;
  logic            do_write;
  logic [1:0]      wr_idx;
  logic [DW-1:0]   wr_data;
  logic [NB-1:0]   wr_strb;
  logic [1:0]      rd_idx;
  logic [DW-1:0]   rd_word;

  // Ready outputs are gated by reset so they read 0 while reset is held.
  assign S_AXI_AWREADY = S_AXI_ARESETN & ((w_state_q == W_IDLE) | (w_state_q == W_GOTDATA));
  assign S_AXI_WREADY  = S_AXI_ARESETN & ((w_state_q == W_IDLE) | (w_state_q == W_GOTADDR));
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = S_AXI_ARESETN & (r_state_q == R_IDLE);
  assign S_AXI_RVALID  = (r_state_q == R_RESP);
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_q;
  assign wr_pulse_o    = wr_pulse_q;
  assign reg0_o        = regs_q[0];
  assign reg1_o        = regs_q[1];
  assign reg2_o        = regs_q[2];
  assign reg3_o        = regs_q[3];

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign rd_idx = S_AXI_ARADDR[3:2];

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    do_write  = 1'b0;
    wr_idx    = waddr_q;
    wr_data   = wdata_q;
    wr_strb   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          do_write  = 1'b1;
          wr_idx    = S_AXI_AWADDR[3:2];
          wr_data   = S_AXI_WDATA;
          wr_strb   = S_AXI_WSTRB;
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          waddr_d   = S_AXI_AWADDR[3:2];
          w_state_d = W_GOTADDR;
        end else if (w_hs) begin
          wdata_d   = S_AXI_WDATA;
          wstrb_d   = S_AXI_WSTRB;
          w_state_d = W_GOTDATA;
        end
      end
      W_GOTADDR: begin
        if (w_hs) begin
          do_write  = 1'b1;
          wr_data   = S_AXI_WDATA;
          wr_strb   = S_AXI_WSTRB;
          w_state_d = W_RESP;
        end
      end
      W_GOTDATA: begin
        if (aw_hs) begin
          do_write  = 1'b1;
          wr_idx    = S_AXI_AWADDR[3:2];
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Byte-lane merge; the pulse fires even when no strobe is set.
  always_comb begin
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
    wr_pulse_d = '0;
    if (do_write) begin
      wr_pulse_d[wr_idx] = 1'b1;
      for (int k = 0; k < NB; k++) begin
        if (wr_strb[k]) regs_d[wr_idx][8*k +: 8] = wr_data[8*k +: 8];
      end
    end
`ifdef FIR_AXI_REG3_STATUS_EN
    regs_d[3] = '0;
`endif
  end

`ifdef FIR_AXI_REG3_STATUS_EN
  assign rd_word = (rd_idx == 2'd3) ? status_i : regs_q[rd_idx];
`else
  assign rd_word = regs_q[rd_idx];
`endif

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d   = rd_word;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_q <= wr_pulse_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  logic unused_inputs;
`ifdef FIR_AXI_REG3_STATUS_EN
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           status_i};
`endif

endmodule

// File: tb/tb_fir_axi_lite_regs.sv
// Self-checking bench for fir_axi_lite_regs: directed scenarios plus randomized traffic
// against a word-array register model.
module tb_fir_axi_lite_regs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, reg0, reg1, reg2, reg3;
  logic [3:0]  wr_pulse;
  logic [31:0] status = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [4];

  always #5 clk = ~clk;

  fir_axi_lite_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3),
    .wr_pulse_o(wr_pulse), .status_i(status)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
    return (old & ~m) | (d & m);
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    int idx;
    idx = int'(a[3:2]);
`ifdef FIR_AXI_REG3_STATUS_EN
    if (idx == 3) return;
`endif
    model[idx] = merge(model[idx], d, s);
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int idx;
    idx = int'(a[3:2]);
`ifdef FIR_AXI_REG3_STATUS_EN
    if (idx == 3) return status;
`endif
    return model[idx];
  endfunction

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0;
    int cyc = 0;
    logic [3:0] exp_pulse;
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      if (aw_done) begin
        checks++;
        if (awready !== 1'b0) begin errors++; $display("FAIL awready_after_aw: got %b want 0", awready); end
      end
      if (w_done) begin
        checks++;
        if (wready !== 1'b0) begin errors++; $display("FAIL wready_after_w: got %b want 0", wready); end
      end
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = a;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = d;
      wstrb   = s;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      cyc++;
      if (cyc > 60) begin
        errors++; $display("FAIL write_timeout: addr %h not accepted", a);
        awvalid = 0; wvalid = 0;
        return;
      end
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    model_write(a, d, s);
    exp_pulse = 4'b0001 << a[3:2];
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("FAIL bvalid_first: got bvalid=%b bresp=%b want 1/00", bvalid, bresp);
    end
    checks++;
    if (wr_pulse !== exp_pulse) begin
      errors++; $display("FAIL wr_pulse: got %b want %b", wr_pulse, exp_pulse);
    end
    checks++;
    if ({reg0, reg1, reg2, reg3} !== {model[0], model[1], model[2], model[3]}) begin
      errors++; $display("FAIL reg_outputs: got %h %h %h %h want %h %h %h %h",
                         reg0, reg1, reg2, reg3, model[0], model[1], model[2], model[3]);
    end
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || wr_pulse !== 4'b0 || awready !== 1'b0 || wready !== 1'b0) begin
        errors++; $display("FAIL bresp_hold: got bvalid=%b pulse=%b awready=%b wready=%b want 1/0000/0/0",
                           bvalid, wr_pulse, awready, wready);
      end
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wr_pulse !== 4'b0) begin
      errors++; $display("FAIL after_bresp: got bvalid=%b awready=%b pulse=%b want 0/1/0000",
                         bvalid, awready, wr_pulse);
    end
  endtask

  task automatic axi_read(input logic [3:0] a, input int r_dly);
    logic [31:0] exp;
    int cyc = 0;
    @(negedge clk);
    arvalid = 1; araddr = a;
    while (!arready) begin
      @(negedge clk);
      cyc++;
      if (cyc > 60) begin
        errors++; $display("FAIL read_timeout: addr %h not accepted", a);
        arvalid = 0;
        return;
      end
    end
    exp = model_read(a);
    @(negedge clk);
    arvalid = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== exp || rresp !== 2'b00 || arready !== 1'b0) begin
      errors++; $display("FAIL read_data @%h: got rvalid=%b rdata=%h rresp=%b arready=%b want 1/%h/00/0",
                         a, rvalid, rdata, rresp, arready, exp);
    end
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp) begin
        errors++; $display("FAIL read_hold @%h: got rvalid=%b rdata=%h want 1/%h", a, rvalid, rdata, exp);
      end
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++; $display("FAIL after_rresp: got rvalid=%b arready=%b want 0/1", rvalid, arready);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, wr_pulse, bresp, rresp} !== '0 ||
        {rdata, reg0, reg1, reg2, reg3} !== '0) begin
      errors++; $display("FAIL %s: got rdy=%b%b%b v=%b%b pulse=%b rdata=%h regs=%h %h %h %h want all 0",
                         name, awready, wready, arready, bvalid, rvalid, wr_pulse, rdata,
                         reg0, reg1, reg2, reg3);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got aw=%b w=%b ar=%b b=%b r=%b want 1 1 1 0 0",
                         awready, wready, arready, bvalid, rvalid);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);
    checks++;
    if (reg0 !== 32'h1 || reg1 !== 32'h2 || reg2 !== 32'h3) begin
      errors++; $display("FAIL basic_regs: got %h %h %h want 1 2 3", reg0, reg1, reg2);
    end
  endtask

  task automatic test_split_aw_w();
    axi_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 3, 0);
    axi_write(4'h4, 32'h0BADF00D, 4'hF, 3, 0, 0);
    axi_read(4'h5, 0);
  endtask

  task automatic test_strobes();
    axi_write(4'h0, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'h12345678, 4'b0101, 0, 0, 0);
    checks++;
    if (reg0 !== 32'hFF34FF78) begin
      errors++; $display("FAIL strobe_merge: got %h want ff34ff78", reg0);
    end
    axi_read(4'h0, 0);
    axi_write(4'h6, 32'h55555555, 4'b0000, 1, 0, 0);
    axi_read(4'h4, 0);
  endtask

  task automatic test_bresp_stall();
    axi_write(4'h8, 32'h00C0FFEE, 4'hF, 0, 0, 5);
    axi_write(4'h0, 32'h11112222, 4'hF, 0, 0, 0);
  endtask

  task automatic test_read_hold_with_write();
    axi_write(4'h8, 32'h01020304, 4'hF, 0, 0, 0);
    fork
      axi_read(4'h8, 4);
      axi_write(4'h8, 32'hA5A5A5A5, 4'hF, 1, 1, 0);
    join
    axi_read(4'h8, 0);
  endtask

  task automatic test_same_edge();
    logic [31:0] old;
    @(negedge clk);
    old = model_read(4'hB);
    awvalid = 1; awaddr = 4'hA; wvalid = 1; wdata = 32'h77778888; wstrb = 4'hF;
    arvalid = 1; araddr = 4'h8;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    model_write(4'h8, 32'h77778888, 4'hF);
    checks++;
    if (rvalid !== 1'b1 || rdata !== old || bvalid !== 1'b1 || reg2 !== model[2]) begin
      errors++; $display("FAIL same_edge: got rvalid=%b rdata=%h bvalid=%b reg2=%h want 1/%h/1/%h",
                         rvalid, rdata, bvalid, reg2, old, model[2]);
    end
    bready = 1; rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;
    axi_read(4'h8, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      status = $urandom;
      axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      axi_read(4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_transaction();
    @(negedge clk);
    awvalid = 1; awaddr = 4'h0; wvalid = 0;
    arvalid = 1; araddr = 4'h8;
    @(negedge clk);
    awvalid = 0; arvalid = 0;
    checks++;
    if (awready !== 1'b0 || wready !== 1'b1 || rvalid !== 1'b1) begin
      errors++; $display("FAIL mid_txn_state: got awready=%b wready=%b rvalid=%b want 0/1/1",
                         awready, wready, rvalid);
    end
    rst_n = 0;
    #1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL stale_after_reset: got bvalid=%b rvalid=%b awready=%b wready=%b want 0/0/1/1",
                         bvalid, rvalid, awready, wready);
    end
    axi_write(4'h0, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    axi_read(4'h0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split_aw_w();
    test_strobes();
    test_bresp_stall();
    test_read_hold_with_write();
    test_same_edge();
    test_random();
    test_reset_mid_transaction();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/fir_axi_lite_regs.md
Name: fir_axi_lite_regs

Overview:
AXI4-Lite slave (responder) register bank for the FIR filter IP; the completer end of the S00_AXI interface that the AXI VIP master drives in the BD wrapper.
- Four 32-bit registers: control, coefficient/sample, plus two spare.
- Independent write and read channel FSMs, one outstanding transaction per direction.
- Register contents and per-register write pulses are exported to the FIR datapath.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.

Ports:
S_AXI_ACLK  in  1  single clock
S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
S_AXI_AWADDR  in  4  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte lane strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  always 2'b00 OKAY
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  4  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00 OKAY
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg0_o..reg3_o  out  32 each  current register contents
wr_pulse_o  out  4  one-cycle pulse, bit n set on the cycle after register n is written
status_i  in  32  core status; used only with the optional feature

Behaviour:
Reset:
- While S_AXI_ARESETN=0: all registers 0; AWREADY, WREADY, BVALID, ARREADY, RVALID, wr_pulse_o all 0; RDATA 0; BRESP and RRESP 00.
- Both FSMs return to IDLE immediately.
- Reset mid-transaction drops the transaction; no response is issued afterwards.

Write FSM (W_IDLE, W_GOTADDR, W_GOTDATA, W_RESP):
- W_IDLE: AWREADY=1 and WREADY=1.
- AW and W handshake in the same cycle: register updated at that edge, next state W_RESP.
- Only AW handshakes: address latched, go to W_GOTADDR (AWREADY=0, WREADY=1).
- Only W handshakes: data and strobes latched, go to W_GOTDATA (WREADY=0, AWREADY=1).
- W_GOTADDR or W_GOTDATA: on the missing handshake, write the register, go to W_RESP.
- W_RESP: BVALID=1 and all write ready signals 0. Hold until BREADY=1, then W_IDLE.
- BVALID rises the cycle after the register write.

Write rules:
- Byte lane k of the register is updated only if WSTRB[k]=1.
- WSTRB=0 writes nothing but still returns OKAY and still pulses wr_pulse_o.
- wr_pulse_o[n] is high exactly one cycle, aligned with BVALID's first cycle.

Read FSM (R_IDLE, R_RESP):
- R_IDLE: ARREADY=1. On handshake, RDATA is captured from register ARADDR[3:2] and the FSM moves to R_RESP.
- R_RESP: RVALID=1, ARREADY=0. RDATA is held stable until RREADY=1, then R_IDLE.
- Read latency: RVALID the cycle after the AR handshake.

Concurrency:
- Read and write channels are fully independent.
- AR handshake on the same edge that writes the same register: RDATA returns the old value.

Addresses:
- Addresses 0x0/0x4/0x8/0xC map to reg0..reg3.
- Unaligned addresses alias to the containing word.
- No SLVERR is ever generated.

Optional Feature:
FIR_AXI_REG3_STATUS_EN
- Defined: reg3 is read-only. Reads return status_i sampled at the AR handshake. Writes to 0xC are accepted with OKAY but change nothing; wr_pulse_o[3] still pulses. reg3_o is 0.
- Undefined: reg3 is an ordinary read/write register; status_i is unused.

Test Plan:
1. Reset release, then write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with AW and W together, then read back each -> RDATA 0x1, 0x2, 0x3, 0x4, all BRESP/RRESP OKAY, reg0_o..reg3_o match.
2. AW presented 3 cycles before W, then W presented 3 cycles before AW, to 0x4 with data 0xDEADBEEF -> both writes complete; BVALID the cycle after the second handshake; wr_pulse_o=4'b0010 for one cycle each time.
3. reg0=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> read returns 0xFF34FF78.
4. Write to 0x8 with BREADY held low 5 cycles -> BVALID held; second AW to 0x0 not accepted (AWREADY=0) until BREADY handshake.
5. Read 0x8 with RREADY low 4 cycles while a write of 0xA5A5A5A5 to 0x8 completes -> RDATA stays at the old value until the RREADY handshake; next read returns 0xA5A5A5A5.
6. Reset asserted while in W_GOTADDR and R_RESP -> all outputs 0 at once; after release, write then read of 0x0 returns the new value with no stale BVALID/RVALID.
